// File: rtl/bicubic_window_fetch_pkg.sv
// Shared constants and state encoding for the bicubic 4x4 window fetcher.
package bicubic_window_fetch_pkg;

   localparam int                WIN_N    = 4;
   localparam int                WIN_TAPS = WIN_N * WIN_N;
   localparam logic signed [2:0] TAP_OFF  = -3'sd1;
   localparam int                ADDR_W   = 14;
   localparam int                SIZE_W   = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      TAIL  = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/bicubic_window_fetch_if.sv
// Request, image-memory and window buses of the bicubic window fetcher.
interface bicubic_window_fetch_if
   import bicubic_window_fetch_pkg::*;
#(
   parameter int PIX_W   = 8,
   parameter int COORD_W = 7
);

   logic                      req_valid;
   logic                      req_ready;
   logic [COORD_W-1:0]        req_x;
   logic [COORD_W-1:0]        req_y;

   logic                      mem_cen;
   logic [ADDR_W-1:0]         mem_a;
   logic [PIX_W-1:0]          mem_q;

   logic                      win_valid;
   logic                      win_ready;
   logic [WIN_TAPS*PIX_W-1:0] win_data;

   modport master (
      output req_valid, req_x, req_y, win_ready, mem_q,
      input  req_ready, mem_cen, mem_a, win_valid, win_data
   );

   modport slave (
      input  req_valid, req_x, req_y, win_ready, mem_q,
      output req_ready, mem_cen, mem_a, win_valid, win_data
   );

endinterface

// File: rtl/bicubic_coord_clamp.sv
// Clamps centre+offset into [0, limit-1]; a zero limit behaves as one.
module bicubic_coord_clamp #(
   parameter int COORD_W = 7,
   parameter int LIM_W   = 5
) (
   input  logic signed [2:0]   offset,
   input  logic [COORD_W-1:0]  centre,
   input  logic [LIM_W-1:0]    limit,
   output logic [COORD_W-1:0]  index
);

   logic signed [8:0] pos;
   logic signed [8:0] hi;
   logic signed [8:0] sel;

   always_comb begin
      pos = $signed({{(9-COORD_W){1'b0}}, centre}) + $signed({{6{offset[2]}}, offset});
      if (limit == '0) begin
         hi = 9'sd0;
      end else begin
         hi = $signed({{(9-LIM_W){1'b0}}, limit}) - 9'sd1;
      end
      if (pos < 9'sd0) begin
         sel = 9'sd0;
      end else if (pos > hi) begin
         sel = hi;
      end else begin
         sel = pos;
      end
      index = COORD_W'(sel);
   end

endmodule

// File: rtl/bicubic_window_fetch.sv
// Fetches a clamped 4x4 neighbourhood from a registered image memory and
// presents it as one packed window under a valid/ready handshake.
module bicubic_window_fetch
   import bicubic_window_fetch_pkg::*;
#(
   parameter int PIX_W   = 8,
   parameter int COORD_W = 7
) (
   input  logic                 CLK,
   input  logic                 RST,
   bicubic_window_fetch_if.slave bus,
   input  logic [COORD_W-1:0]   H0,
   input  logic [COORD_W-1:0]   V0,
   input  logic [SIZE_W-1:0]    SW,
   input  logic [SIZE_W-1:0]    SH,
   output logic                 busy
);

   state_t                    state;
   state_t                    state_nx;
   logic [3:0]                k;
   logic [COORD_W-1:0]        x_q, y_q, h0_q, v0_q;
   logic [SIZE_W-1:0]         sw_q, sh_q;
   logic signed [2:0]         off_r, off_c;
   logic [COORD_W-1:0]        row_idx, col_idx;
   logic [COORD_W-1:0]        row, col;
   logic [ADDR_W-1:0]         addr;
   logic [ADDR_W-1:0]         mem_a_q;
   logic                      vld_p1;
   logic [3:0]                slot_idx_p1;
   logic [PIX_W-1:0]          slot [WIN_TAPS];

   assign off_r = $signed({1'b0, k[3:2]}) + TAP_OFF;
   assign off_c = $signed({1'b0, k[1:0]}) + TAP_OFF;

   bicubic_coord_clamp #(.COORD_W(COORD_W), .LIM_W(SIZE_W)) u_row_clamp (
      .offset (off_r),
      .centre (y_q),
      .limit  (sh_q),
      .index  (row_idx)
   );

   bicubic_coord_clamp #(.COORD_W(COORD_W), .LIM_W(SIZE_W)) u_col_clamp (
      .offset (off_c),
      .centre (x_q),
      .limit  (sw_q),
      .index  (col_idx)
   );

   assign row  = v0_q + row_idx;
   assign col  = h0_q + col_idx;
   assign addr = ADDR_W'({row, col});

   always_comb begin
      state_nx      = state;
      bus.req_ready = 1'b0;
      bus.win_valid = 1'b0;
      bus.mem_cen   = 1'b1;
      bus.mem_a     = mem_a_q;
      busy          = 1'b1;
      unique case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            busy          = 1'b0;
            if (bus.req_valid) state_nx = FETCH;
         end
         FETCH: begin
            // Address is presented in the issue cycle so the registered
            // memory returns it exactly one cycle later.
            bus.mem_cen = 1'b0;
            bus.mem_a   = addr;
            if (k == 4'(WIN_TAPS-1)) state_nx = TAIL;
         end
         TAIL: state_nx = HOLD;
         HOLD: begin
            bus.win_valid = 1'b1;
            if (bus.win_ready) state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         k           <= '0;
         mem_a_q     <= '0;
         vld_p1      <= 1'b0;
         slot_idx_p1 <= '0;
         x_q         <= '0;
         y_q         <= '0;
         h0_q        <= '0;
         v0_q        <= '0;
         sw_q        <= '0;
         sh_q        <= '0;
      end else begin
         state       <= state_nx;
         // p1: read k issued last cycle, data arrives on mem_q now
         vld_p1      <= (state == FETCH);
         slot_idx_p1 <= k;
         if (state == IDLE && bus.req_valid) begin
            x_q  <= bus.req_x;
            y_q  <= bus.req_y;
            h0_q <= H0;
            v0_q <= V0;
            sw_q <= SW;
            sh_q <= SH;
            k    <= '0;
         end
         if (state == FETCH) begin
            k       <= k + 4'd1;
            mem_a_q <= addr;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < WIN_TAPS; i++) slot[i] <= '0;
      end else if (vld_p1) begin
         slot[slot_idx_p1] <= bus.mem_q;
      end
   end

   for (genvar g = 0; g < WIN_TAPS; g++) begin : g_pack
      assign bus.win_data[g*PIX_W +: PIX_W] = slot[g];
   end

endmodule

// File: tb/tb_bicubic_window_fetch.sv
// Scoreboard bench for bicubic_window_fetch against a q=row+col memory model.
module tb_bicubic_window_fetch;
   import bicubic_window_fetch_pkg::*;

   typedef struct {
      logic [127:0] win;
      int           s0;
      int           s5;
      int           s15;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [6:0]  H0, V0;
   logic [4:0]  SW, SH;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q[$];
   logic [13:0] exp_a[$];
   exp_t        mon_e;
   logic [13:0] mon_a;

   bicubic_window_fetch_if #(.PIX_W(8), .COORD_W(7)) bus ();

   bicubic_window_fetch #(.PIX_W(8), .COORD_W(7)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .bus  (bus),
      .H0   (H0),
      .V0   (V0),
      .SW   (SW),
      .SH   (SH),
      .busy (busy)
   );

   always #5 CLK = ~CLK;

   // Registered image memory: q = row + col of the sampled address.
   always @(posedge CLK) begin
      if (!bus.mem_cen) bus.mem_q <= 8'(bus.mem_a[13:7] + bus.mem_a[6:0]);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampi(int v, int lim);
      int hi;
      hi = (lim == 0) ? 0 : lim - 1;
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Expected addresses go to exp_a; the expected window is returned.
   task automatic expect_reads(input int h0, v0, sw, sh, x, y, output logic [127:0] w);
      int row, col;
      w = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            row = v0 + clampi(y + r - 1, sh);
            col = h0 + clampi(x + c - 1, sw);
            w[8*(4*r+c) +: 8] = 8'(row + col);
            exp_a.push_back(14'(row * 128 + col));
         end
      end
   endtask

   task automatic drive_req(input int h0, v0, sw, sh, x, y);
      H0 = 7'(h0); V0 = 7'(v0); SW = 5'(sw); SH = 5'(sh);
      bus.req_x = 7'(x); bus.req_y = 7'(y);
      bus.req_valid = 1'b1;
      @(posedge CLK); #1;
      bus.req_valid = 1'b0;
      // Disturb every latched input; the window in flight must not change.
      H0 = 7'h55; V0 = 7'h2a; SW = 5'd1; SH = 5'd31;
      bus.req_x = 7'h7f; bus.req_y = 7'h00;
   endtask

   task automatic run_req(input int h0, v0, sw, sh, x, y, s0, s5, s15, stall);
      exp_t        e;
      int          n;
      logic [127:0] held;
      expect_reads(h0, v0, sw, sh, x, y, e.win);
      e.s0 = s0; e.s5 = s5; e.s15 = s15;
      exp_q.push_back(e);
      bus.win_ready = (stall == 0);
      drive_req(h0, v0, sw, sh, x, y);
      chk("busy_after_accept", busy, 1);
      n = 0;
      while (!bus.win_valid && n < 40) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("latency_edges", n, 17);
      if (stall > 0) begin
         held = bus.win_data;
         repeat (stall) begin
            @(posedge CLK); #1;
            chk("stall_win_data", bus.win_data, held);
            chk("stall_win_valid", bus.win_valid, 1);
            chk("stall_req_ready", bus.req_ready, 0);
         end
         bus.win_ready = 1'b1;
      end
      @(posedge CLK); #1;
      chk("req_ready_after_hs", bus.req_ready, 1);
      chk("win_valid_after_hs", bus.win_valid, 0);
   endtask

   always @(negedge CLK) begin
      if (bus.win_valid && bus.win_ready) begin
         if (exp_q.size() == 0) begin
            chk("win_unexpected", bus.win_data, '0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("win_data", bus.win_data, mon_e.win);
            chk("slot0", bus.win_data[7:0], 128'(mon_e.s0));
            chk("slot5", bus.win_data[47:40], 128'(mon_e.s5));
            chk("slot15", bus.win_data[127:120], 128'(mon_e.s15));
         end
      end
   end

   always @(negedge CLK) begin
      if (!bus.mem_cen) begin
         if (exp_a.size() == 0) begin
            chk("addr_unexpected", bus.mem_a, '1);
         end else begin
            mon_a = exp_a.pop_front();
            chk("mem_a", bus.mem_a, mon_a);
         end
      end
   end

   initial begin
      logic [127:0] dummy;
      bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0;
      bus.win_ready = 1'b1; bus.mem_q = '0;
      H0 = '0; V0 = '0; SW = '0; SH = '0;
      #12;
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_win_valid", bus.win_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_cen", bus.mem_cen, 1);
      chk("rst_mem_a", bus.mem_a, 0);
      chk("rst_win_data", bus.win_data, 0);
      #1 RST = 1'b0;

      // centre (5,5): rows 24..27, cols 14..17
      run_req(10, 20, 16, 16, 5, 5, 38, 40, 44, 0);
      // top-left corner
      run_req(10, 20, 16, 16, 0, 0, 30, 30, 34, 0);
      // far edge of a 4x4 ROI
      run_req(10, 20, 4, 4, 3, 3, 34, 36, 36, 0);
      // back-pressure for 10 cycles
      run_req(0, 0, 8, 8, 2, 6, 6, 8, 11, 10);

      // reset while read 7 is in flight
      expect_reads(10, 20, 16, 16, 5, 5, dummy);
      drive_req(10, 20, 16, 16, 5, 5);
      repeat (7) @(posedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("abort_win_valid", bus.win_valid, 0);
      chk("abort_mem_cen", bus.mem_cen, 1);
      chk("abort_req_ready", bus.req_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_win_data", bus.win_data, 0);
      exp_a.delete();
      @(posedge CLK); #3 RST = 1'b0;
      @(posedge CLK); #1;
      chk("abort_still_idle", bus.win_valid, 0);

      run_req(50, 60, 10, 10, 1, 8, 117, 119, 122, 0);
      // zero-sized ROI: every read hits {V0,H0}
      run_req(30, 40, 0, 0, 9, 9, 70, 70, 70, 0);
      // centre far outside the ROI: every read hits the edge pixel
      run_req(1, 2, 5, 6, 100, 120, 12, 12, 12, 0);

      repeat (3) @(posedge CLK);
      chk("sb_win_empty", exp_q.size(), 0);
      chk("sb_addr_empty", exp_a.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bicubic_window_fetch.md
BICUBIC_WINDOW_FETCH -- requirements
Module: bicubic_window_fetch

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter COORD_W, default 7, image coordinate width in bits.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid  input  1, and req_ready  output  1: window request handshake.
REQ-006 SHALL have ports req_x and req_y  input  7 each: ROI-relative integer source coordinate of the window centre.
REQ-007 SHALL have ports H0 and V0  input  7 each: ROI origin column and row in the 100x100 source image.
REQ-008 SHALL have ports SW and SH  input  5 each: ROI width and height.
REQ-009 SHALL have ports mem_cen  output  1  active-low image memory enable, mem_a  output  14  address {row[6:0], col[6:0]}, and mem_q  input  8  read data.
REQ-010 SHALL have ports win_valid  output  1, win_ready  input  1, and win_data  output  128: packed 4x4 window.
REQ-011 SHALL have port busy  output  1, high in every state except IDLE.

Function
REQ-012 SHALL implement the states IDLE, FETCH, TAIL and HOLD.
REQ-013 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid&req_ready at an edge, then IDLE->FETCH.
REQ-014 SHALL latch req_x, req_y, H0, V0, SW and SH on acceptance; later input changes SHALL NOT affect the window in flight.
REQ-015 SHALL, in FETCH, issue exactly 16 reads on consecutive cycles, index k=0..15, with r=k/4 and c=k%4, holding mem_cen=0.
REQ-016 SHALL compute row = V0 + clamp(req_y+r-1, 0, SH-1) and col = H0 + clamp(req_x+c-1, 0, SW-1), using signed 9-bit intermediates.
REQ-017 SHALL treat SW=0 or SH=0 as 1, so the offset on that axis is forced to 0.
REQ-018 SHALL assume the memory is registered: mem_q is valid one cycle after the address; read k SHALL be captured into slot k one cycle after issue.
REQ-019 SHALL go FETCH->TAIL after k=15 is issued; TAIL captures slot 15, then TAIL->HOLD, and mem_cen=1 in TAIL.
REQ-020 SHALL place slot k at win_data[8k+7:8k].
REQ-021 SHALL assert win_valid in HOLD only; the latency from the acceptance edge to win_valid high SHALL be exactly 17 edges.
REQ-022 SHALL keep win_data stable while win_valid=1 and win_ready=0, with no timeout.
REQ-023 SHALL go HOLD->IDLE on win_valid&win_ready; req_ready rises on the following cycle, so there are no overlapping requests.
REQ-024 SHALL keep mem_cen=1 and mem_a at its last value outside FETCH.
REQ-025 SHALL tolerate req_x and req_y beyond the ROI; clamping alone bounds the addresses, and all 16 reads SHALL then hit the edge pixel.

Reset
REQ-026 SHALL, on RST: go to state IDLE, req_ready=1, win_valid=0, busy=0, mem_cen=1, mem_a=0, win_data=0, and clear the slot counter.
REQ-027 SHALL, on RST asserted mid-FETCH or in HOLD, abort the transaction immediately; no partial window SHALL ever be presented.

Structure
REQ-028 SHALL put the state encoding, the window size 4, the tap offset -1 and the 14-bit address width in the shared bicubic package.
REQ-029 SHALL use one combinational sub-module, bicubic_coord_clamp (offset, centre, limit -> clamped index), instantiated once per axis.
REQ-030 SHALL build the window register file as a 16x8 flop array, with no RAM inference.

Verification
REQ-031 SHALL cover: memory model q={row+col}[7:0]; H0=10, V0=20, SW=16, SH=16, req=(5,5) -> reads rows 24..27 and cols 14..17; slot0=38, slot15=44; win_valid exactly 17 edges after acceptance.
REQ-032 SHALL cover the corner: req=(0,0) -> slot0 row 20 col 10 = 30; slot5 = 30; slot15 = row 22 col 12 = 34.
REQ-033 SHALL cover the far edge: SW=4, SH=4, req=(3,3) -> columns 12,13,13,13 and rows 22,23,23,23; slot15 = 36.
REQ-034 SHALL cover back-pressure: win_ready held low 10 cycles -> win_data unchanged, req_ready=0 throughout; after the handshake req_ready=1 next cycle.
REQ-035 SHALL cover reset mid-operation: RST asserted at slot 7 -> win_valid=0, mem_cen=1 and req_ready=1 immediately; the next request completes normally.
REQ-036 SHALL cover degenerate size: SW=0, SH=0, req=(9,9) -> all 16 addresses = {V0,H0}, all slots equal.
